// File: rtl/multdiv.sv
// Sequential signed multiply/divide unit: one iteration per clock, WIDTH iterations
// per operation, registered result with exception flag and a one-cycle ready pulse.
module multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateType;

    stateType           state, nextState;
    logic [CW-1:0]      count, countNext;
    logic [2*WIDTH-1:0] acc, accNext;
    logic [WIDTH-1:0]   opB, opBNext;
    logic               negRes, negResNext;
    logic [WIDTH-1:0]   resultNext;
    logic               exceptionNext, rdyNext;

    logic               start, running, lastStep;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic               divGe, mulOvf;
    logic [2*WIDTH-1:0] mulStep, divStep, product;
    logic [WIDTH-1:0]   quotient;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign running  = (state == MULT) || (state == DIV);
    assign lastStep = running && (count == CW'(WIDTH));
    assign busy     = running;

    assign absA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign absB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
    assign mulStep = {mulSum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}. The remainder stays below the
    // divisor, so the borrow bit of the trial subtraction alone decides the quotient bit.
    assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opB};
    assign divGe    = ~divDiff[WIDTH];
    assign divStep  = {(divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divGe};

    assign product  = negRes ? -acc : acc;
    assign mulOvf   = ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
    assign quotient = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        nextState     = state;
        countNext     = count;
        accNext       = acc;
        opBNext       = opB;
        negResNext    = negRes;
        resultNext    = data_result;
        exceptionNext = data_exception;
        rdyNext       = 1'b0;

        if (running && !lastStep) begin
            countNext = count + CW'(1);
            accNext   = (state == MULT) ? mulStep : divStep;
        end

        if (lastStep) begin
            rdyNext   = 1'b1;
            nextState = DONE;
            if (state == MULT) begin
                resultNext    = product[WIDTH-1:0];
                exceptionNext = mulOvf;
            end else if (opB == '0) begin
                resultNext    = '0;
                exceptionNext = 1'b1;
            end else begin
                resultNext    = quotient;
                exceptionNext = ~negRes & acc[WIDTH-1];
            end
        end

        // A start aborts an operation in flight, but one completing on this edge still reports.
        if (start) begin
            nextState  = ctrl_MULT ? MULT : DIV;
            countNext  = '0;
            negResNext = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            accNext    = {{WIDTH{1'b0}}, (ctrl_MULT ? absB : absA)};
            opBNext    = ctrl_MULT ? absA : absB;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            opB            <= '0;
            negRes         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= nextState;
            count          <= countNext;
            acc            <= accNext;
            opB            <= opBNext;
            negRes         <= negResNext;
            data_result    <= resultNext;
            data_exception <= exceptionNext;
            data_resultRDY <= rdyNext;
        end
    end

endmodule

// File: doc/multdiv.md
# multdiv

Sequential signed multiply/divide unit for the CPU execute stage, sitting beside the combinational ALU (bitwise_or, add, shifts) and sharing its operand buses. It accepts a one-cycle start command, iterates one bit per clock, and presents a 32-bit result with an exception flag and a one-cycle ready pulse. The pipeline stalls on its busy state and writes back `data_result` when `data_resultRDY` pulses.

## Interface
- `WIDTH`, 32, operand/result width; latency and exception rules scale with it; only 32 is exercised in the processor.
- `clock` in 1, single clock; all state changes on the rising edge.
- `reset` in 1, asynchronous, active-high; forces IDLE and clears all outputs.
- `data_operandA` in WIDTH, multiplicand/dividend, two's complement.
- `data_operandB` in WIDTH, multiplier/divisor, two's complement.
- `ctrl_MULT` in 1, start-multiply pulse; sampled on the rising edge.
- `ctrl_DIV` in 1, start-divide pulse; sampled on the rising edge.
- `data_result` out WIDTH, product low word or quotient; held until the next start.
- `data_exception` out 1, overflow or divide-by-zero flag; valid and held with `data_result`.
- `data_resultRDY` out 1, single-cycle completion pulse.
- `busy` out 1, high from the start edge until the ready edge; the stall source.

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE, start sampled: latch A/B into internal registers, clear the iteration counter, and go to MULT (`ctrl_MULT`) or DIV (`ctrl_DIV`).
  - Both starts high together: MULT wins.
- Operands need only be valid on the start edge; later changes on the input buses are ignored.
- MULT: 32 iterations of shift-add (or radix-2 Booth) on a 2·WIDTH-bit accumulator.
  - Result = low WIDTH bits of the full signed product.
  - Exception = 1 when the product does not fit in signed WIDTH, i.e. bits [2·WIDTH-1:WIDTH-1] are not all equal.
- DIV: 32 iterations of restoring division on magnitudes; signs are fixed after the last iteration.
  - Quotient truncates toward zero; the remainder is discarded.
  - Sign of the quotient = signA XOR signB, with a zero quotient always +0.
- Divide by zero: result 0, exception 1. Latency is unchanged (no early exit).
- −2^(WIDTH−1) / −1: result 0x80000000, exception 1.
- Counter reaches WIDTH: load `data_result` and `data_exception`, pulse `data_resultRDY`, then go to DONE. DONE behaves as IDLE but shows the held result.
- Start while busy: the operation in flight is aborted. The new operands are latched and the counter restarts. No ready pulse is issued for the aborted operation, and `data_result` keeps its prior value.
- Reset, including mid-operation: state IDLE, counter 0, `data_result` 0, `data_exception` 0, `data_resultRDY` 0, `busy` 0. No pulse is issued after reset is released.

## Timing
- Start edge = edge 0.
- Iterations occur on edges 1..WIDTH.
- On edge WIDTH+1 (edge 33) `data_result`/`data_exception` update and `data_resultRDY` goes high. `data_resultRDY` falls on edge 34.
- `busy` rises on edge 0 and falls on edge 33, at the same edge where ready rises.
- Back-to-back: a start sampled on edge 33 or later begins a new operation. Its result is ready 33 edges after its own start.
- A start on edge 33 itself is legal: ready still pulses for the completing operation and the new one begins.
- Outputs are registered only; no combinational path from any input to any output.

## Test plan
- Reset mid-MULT: assert `reset` asynchronously at edge 10 of 7×6. Required: all outputs 0 immediately; no `data_resultRDY` at edge 33.
- MULT 7×−6: ready exactly 33 edges after the start, with result −42 and exception 0. Then 65536×65536: result 0, exception 1.
- MULT −2147483648×1: result 0x80000000, exception 0. Then −2147483648×−1: exception 1.
- DIV −7/2: result −3, exception 0. Then 100/0: result 0, exception 1, ready at edge 33. Then −2147483648/−1: result 0x80000000, exception 1.
- Abort: start DIV 50/5, then at edge 12 start MULT 3×4. Required: a single ready pulse, 33 edges after the second start, with result 12; the result stays at its prior value until then.
- Simultaneous `ctrl_MULT`+`ctrl_DIV` with 9 and 3: result 27. Then a back-to-back start on the ready edge (DIV 9/3): second ready 33 edges later with result 3.
